// File: rtl/chunked_addsub_pkg.sv
// Shared types and constants for the chunked add/subtract unit.
// Holds the FSM state encoding, the operation mode constants and the index-width helper.
package chunked_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // A counter for a single chunk still needs one bit.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Operand/result handshake bundle for chunked_addsub.
// The slave modport is the arithmetic unit; the master modport is its user.
interface chunked_addsub_if #(parameter int N = 16);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         overflow;

    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, s, cout, overflow
    );

    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, s, cout, overflow
    );

endinterface

// File: rtl/chunked_addsub_chunk.sv
// Combinational W-bit adder slice used once per cycle by chunked_addsub.
// cmsb is the carry into the slice's top bit, needed for signed overflow.
module addsub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    // The top sum bit is a^b^carry-in, so the carry-in can be recovered from it.
    assign cmsb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle N-bit adder/subtractor that processes one W-bit chunk per clock.
// Subtraction stores the inverted y operand and seeds the carry with 1.
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    chunked_addsub_if.slave bus
);

    localparam int SAFE_W = (W < 1) ? 1 : W;
    localparam int CHUNKS = N / SAFE_W;
    localparam int IDXW   = idx_width(CHUNKS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

    if (W < 1 || N < W || (N % SAFE_W) != 0) begin : g_param_check
        $error("chunked_addsub: N must be a positive multiple of W (W >= 1)");
    end

    state_t          state_reg, state_next;
    logic [IDXW-1:0] idx_reg;
    logic            carry_reg;
    logic [N-1:0]    x_reg;
    logic [N-1:0]    y_reg;
    logic [N-1:0]    res_reg;
    logic            cout_reg;
    logic            ovf_reg;

    logic [W-1:0]    a_sel, b_sel, sum;
    logic            c_out, c_msb;

    assign a_sel = x_reg[int'(idx_reg) * W +: W];
    assign b_sel = y_reg[int'(idx_reg) * W +: W];

    addsub_chunk #(.W(W)) u_chunk (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (carry_reg),
        .sum  (sum),
        .cout (c_out),
        .cmsb (c_msb)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)        state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    if (bus.out_ready)       state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            res_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_reg     <= bus.x;
                        y_reg     <= (bus.sub == MODE_SUB) ? ~bus.y : bus.y;
                        carry_reg <= (bus.sub == MODE_SUB);
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    res_reg[int'(idx_reg) * W +: W] <= sum;
                    carry_reg <= c_out;
                    idx_reg   <= idx_reg + IDXW'(1);
                    // The last slice carries the operand MSB, so its carries give cout/overflow.
                    if (idx_reg == LAST_IDX) begin
                        cout_reg <= c_out;
                        ovf_reg  <= c_msb ^ c_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.s         = res_reg;
    assign bus.cout      = cout_reg;
    assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: a 16/4 instance and an 8/8 instance.
// Directed table vectors, stall/reset sequences and random ops against an arithmetic model.
module tb_chunked_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    chunked_addsub_if #(.N(16)) if16 ();
    chunked_addsub_if #(.N(8))  if8 ();

    chunked_addsub #(.N(16), .W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    chunked_addsub #(.N(8),  .W(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic        sb;
        logic [15:0] es;
        logic        ec;
        logic        eov;
    } tv_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {overflow, cout, s} from integer arithmetic on n-bit operands.
    function automatic logic [17:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                          input logic sb);
        longint modv = longint'(1) << n;
        longint half = modv / 2;
        longint av   = longint'(a) % modv;
        longint bv   = longint'(b) % modv;
        longint sa   = (av >= half) ? av - modv : av;
        longint sbv  = (bv >= half) ? bv - modv : bv;
        longint r, sr;
        logic   c, ov;
        if (sb) begin
            r  = av - bv;
            c  = (av >= bv);
            sr = sa - sbv;
        end else begin
            r  = av + bv;
            c  = (r >= modv);
            sr = sa + sbv;
        end
        r  = ((r % modv) + modv) % modv;
        ov = (sr < -half) || (sr >= half);
        return {ov, c, 16'(r)};
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sb);
        if (w == 16) begin
            if16.in_valid = v; if16.x = a; if16.y = b; if16.sub = sb;
        end else begin
            if8.in_valid = v; if8.x = a[7:0]; if8.y = b[7:0]; if8.sub = sb;
        end
    endtask

    task automatic set_oready(input int w, input logic v);
        if (w == 16) if16.out_ready = v;
        else         if8.out_ready  = v;
    endtask

    function automatic logic in_ready_of(input int w);
        return (w == 16) ? if16.in_ready : if8.in_ready;
    endfunction

    function automatic logic ovalid_of(input int w);
        return (w == 16) ? if16.out_valid : if8.out_valid;
    endfunction

    function automatic logic [17:0] result_of(input int w);
        if (w == 16) return {if16.overflow, if16.cout, if16.s};
        return {if8.overflow, if8.cout, 8'h00, if8.s};
    endfunction

    task automatic start_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sb);
        int waited = 0;
        while (!in_ready_of(w) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready before accept", 32'(in_ready_of(w)), 32'd1);
        drive(w, 1'b1, a, b, sb);
        @(posedge clk); #1;
        // Scramble the inputs so a result depending on them after acceptance shows up.
        drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    endtask

    task automatic wait_valid(input int w, output int lat);
        lat = 0;
        while (!ovalid_of(w) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input int w);
        set_oready(w, 1'b1);
        @(posedge clk); #1;
        set_oready(w, 1'b0);
        check("out_valid after handshake", 32'(ovalid_of(w)), 32'd0);
        check("in_ready after handshake", 32'(in_ready_of(w)), 32'd1);
    endtask

    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sb,
                          input logic early, input logic [17:0] exp, input string tag);
        int lat;
        logic [17:0] got;
        start_op(w, a, b, sb);
        set_oready(w, early);
        wait_valid(w, lat);
        got = result_of(w);
        check({tag, " latency"}, 32'(lat), (w == 16) ? 32'd4 : 32'd1);
        check({tag, " result"}, 32'(got), 32'(exp));
        $display("[%s] N=%0d 0x%h %s 0x%h -> s=0x%h cout=%b ovf=%b lat=%0d", tag, w, a,
                 sb ? "-" : "+", b, got[15:0], got[16], got[17], lat);
        handshake(w);
    endtask

    task automatic stall_test(input int w, input logic [15:0] a, input logic [15:0] b, input logic sb);
        int lat;
        logic [17:0] snap;
        start_op(w, a, b, sb);
        wait_valid(w, lat);
        snap = result_of(w);
        check("stall result", 32'(snap), 32'(model(w, a, b, sb)));
        for (int i = 0; i < 3; i++) begin
            drive(w, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            check("stall hold", 32'(result_of(w)), 32'(snap));
            check("stall in_ready", 32'(in_ready_of(w)), 32'd0);
            check("stall out_valid", 32'(ovalid_of(w)), 32'd1);
        end
        drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
        $display("[stall] N=%0d 0x%h %s 0x%h held -> s=0x%h", w, a, sb ? "-" : "+", b, snap[15:0]);
        handshake(w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tv_t tv[10];
        int  seen;
        logic [15:0] ra, rb;
        logic        rs;

        tv[0] = '{16, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[1] = '{16, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{16, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tv[3] = '{16, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tv[4] = '{16, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        tv[5] = '{16, 16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[6] = '{8,  16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
        tv[7] = '{8,  16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[8] = '{8,  16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1};
        tv[9] = '{8,  16'h0000, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(8,  1'b0, 16'h0, 16'h0, 1'b0);
        set_oready(16, 1'b0);
        set_oready(8,  1'b0);
        #3;
        check("reset result16", 32'(result_of(16)), 32'd0);
        check("reset out_valid16", 32'(ovalid_of(16)), 32'd0);
        check("reset in_ready16", 32'(in_ready_of(16)), 32'd1);
        check("reset in_ready8", 32'(in_ready_of(8)), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("[reset] released");

        for (int i = 0; i < 10; i++)
            run_op(tv[i].w, tv[i].a, tv[i].b, tv[i].sb, 1'b0,
                   {tv[i].eov, tv[i].ec, tv[i].es}, "table");

        stall_test(16, 16'h0123, 16'h0456, 1'b0);
        run_op(16, 16'hABCD, 16'h1234, 1'b1, 1'b0, model(16, 16'hABCD, 16'h1234, 1'b1), "post-stall");
        stall_test(8, 16'h0040, 16'h0050, 1'b0);
        run_op(8, 16'h0010, 16'h0020, 1'b1, 1'b0, model(8, 16'h0010, 16'h0020, 1'b1), "post-stall");

        // Abort an operation two chunks in; nothing may come out of it.
        start_op(16, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("abort result", 32'(result_of(16)), 32'd0);
        check("abort out_valid", 32'(ovalid_of(16)), 32'd0);
        check("abort in_ready", 32'(in_ready_of(16)), 32'd1);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ovalid_of(16)) seen++;
        end
        check("abort no out_valid", 32'(seen), 32'd0);
        $display("[abort] reset in RUN, out_valid seen %0d times", seen);
        run_op(16, 16'h1234, 16'h1111, 1'b0, 1'b0, 18'h02345, "after-abort");

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            run_op(16, ra, rb, rs, 1'($urandom), model(16, ra, rb, rs), "rand16");
        end
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rs = 1'($urandom);
            run_op(8, ra, rb, rs, 1'($urandom), model(8, ra, rb, rs), "rand8");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
